// File: rtl/valid_pattern_generator_if.sv
// Valid-lane pattern generator handshake bundle.
// Ports: block controls, TVLD_L word, busy/done status; inject pins under VALID_ERR_INJECT_EN.
interface valid_pattern_generator_if;
    logic        i_enable_generator;
    logic        i_enable_128;
    logic        i_enable_cons;
    logic        i_start;
    logic        i_stop;
    logic        i_data_valid;
    logic [31:0] TVLD_L;
    logic        o_busy;
    logic        o_pattern_done;
`ifdef VALID_ERR_INJECT_EN
    logic        i_inject_err;
    logic [31:0] i_err_mask;
`endif

    modport master (
`ifdef VALID_ERR_INJECT_EN
        output i_inject_err,
        output i_err_mask,
`endif
        output i_enable_generator,
        output i_enable_128,
        output i_enable_cons,
        output i_start,
        output i_stop,
        output i_data_valid,
        input  TVLD_L,
        input  o_busy,
        input  o_pattern_done
    );

    modport slave (
`ifdef VALID_ERR_INJECT_EN
        input  i_inject_err,
        input  i_err_mask,
`endif
        input  i_enable_generator,
        input  i_enable_128,
        input  i_enable_cons,
        input  i_start,
        input  i_stop,
        input  i_data_valid,
        output TVLD_L,
        output o_busy,
        output o_pattern_done
    );
endinterface

// File: rtl/valid_pattern_generator.sv
// Mainband TX valid-lane generator: VALTRAIN burst/continuous runs and mission framing.
// Ports: i_clk, i_rst_n (async low), bus (slave): controls in, TVLD_L/o_busy/o_pattern_done out.
// Optional macro VALID_ERR_INJECT_EN: XORs i_err_mask into pattern beats when i_inject_err=1.
module valid_pattern_generator #(
    parameter int ITERATIONS = 128,
    parameter int BEAT_CNT_W = 8
) (
    input logic                      i_clk,
    input logic                      i_rst_n,
    valid_pattern_generator_if.slave bus
);

    localparam logic [31:0] PATTERN = 32'hF0F0_F0F0;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT =
        BEAT_CNT_W'(ITERATIONS / 4 - 1);
    localparam logic [BEAT_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        CONT,
        DONE
    } state_t;

    state_t                state;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [31:0]           tvld_q;
    logic                  busy_q;
    logic                  done_q;

    logic        en;
    logic        mode_burst;
    logic        mode_cont;
    logic        mode_mission;
    logic [31:0] beat_word;

    assign en           = bus.i_enable_generator;
    assign mode_burst   = !bus.i_enable_cons &&  bus.i_enable_128;
    assign mode_cont    =  bus.i_enable_cons && !bus.i_enable_128;
    assign mode_mission = !bus.i_enable_cons && !bus.i_enable_128;

`ifdef VALID_ERR_INJECT_EN
    assign beat_word = bus.i_inject_err ? (PATTERN ^ bus.i_err_mask)
                                        : PATTERN;
`else
    assign beat_word = PATTERN;
`endif

    assign bus.TVLD_L         = tvld_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_pattern_done = done_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            tvld_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q   <= 1'b0;
                    beat_cnt <= '0;
                    if (bus.i_start && en && mode_burst) begin
                        state  <= BURST;
                        tvld_q <= beat_word;
                        busy_q <= 1'b1;
                    end else if (bus.i_start && en && mode_cont) begin
                        state  <= CONT;
                        tvld_q <= beat_word;
                        busy_q <= 1'b1;
                    end else begin
                        // Mission framing: one cycle behind i_data_valid.
                        tvld_q <= (en && mode_mission && bus.i_data_valid)
                                  ? PATTERN : '0;
                        busy_q <= 1'b0;
                    end
                end
                BURST: begin
                    if (!en || !mode_burst) begin
                        state    <= IDLE;
                        tvld_q   <= '0;
                        busy_q   <= 1'b0;
                        beat_cnt <= '0;
                    end else if (beat_cnt == LAST_BEAT) begin
                        // The start beat already went out from IDLE,
                        // so this edge closes the run.
                        state    <= DONE;
                        tvld_q   <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        beat_cnt <= '0;
                    end else begin
                        tvld_q   <= beat_word;
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                CONT: begin
                    if (!en || !mode_cont) begin
                        state    <= IDLE;
                        tvld_q   <= '0;
                        busy_q   <= 1'b0;
                        beat_cnt <= '0;
                    end else if (bus.i_stop) begin
                        state    <= DONE;
                        tvld_q   <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        beat_cnt <= '0;
                    end else begin
                        tvld_q <= beat_word;
                        if (beat_cnt != CNT_MAX) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    tvld_q   <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    beat_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_valid_pattern_generator.sv
// Self-checking bench for valid_pattern_generator.
// Beat-count reference model plus directed literal checks.
module tb_valid_pattern_generator;

    localparam int ITER = 128;
    localparam int NBEATS = ITER / 4;
    localparam logic [31:0] P = 32'hF0F0_F0F0;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic chk_en = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    valid_pattern_generator_if bus ();

    valid_pattern_generator #(
        .ITERATIONS(ITER),
        .BEAT_CNT_W(8)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: run kind and beats already sent.
    int          m_phase;   // 0 idle, 1 burst, 2 cont, 3 done
    int          m_sent;
    logic [1:0]  m_md;
    logic [31:0] m_word;
    logic [31:0] e_tvld;
    logic        e_busy;
    logic        e_done;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_phase = 0;
            m_sent  = 0;
            e_tvld  = '0;
            e_busy  = 1'b0;
            e_done  = 1'b0;
        end else begin
            m_md   = {bus.i_enable_cons, bus.i_enable_128};
            m_word = P;
`ifdef VALID_ERR_INJECT_EN
            if (bus.i_inject_err) m_word = P ^ bus.i_err_mask;
`endif
            e_done = 1'b0;
            if (m_phase == 3) begin
                m_phase = 0;
                e_tvld  = '0;
                e_busy  = 1'b0;
            end else if (m_phase == 0) begin
                if (bus.i_start && bus.i_enable_generator &&
                    (m_md == 2'b01 || m_md == 2'b10)) begin
                    m_phase = int'(m_md);
                    m_sent  = 1;
                    e_tvld  = m_word;
                    e_busy  = 1'b1;
                end else begin
                    e_tvld = (bus.i_enable_generator && m_md == 2'b00 &&
                              bus.i_data_valid) ? P : '0;
                    e_busy = 1'b0;
                end
            end else if (!bus.i_enable_generator || int'(m_md) != m_phase) begin
                m_phase = 0;
                e_tvld  = '0;
                e_busy  = 1'b0;
            end else if ((m_phase == 1 && m_sent == NBEATS) ||
                         (m_phase == 2 && bus.i_stop)) begin
                m_phase = 3;
                e_tvld  = '0;
                e_busy  = 1'b0;
                e_done  = 1'b1;
            end else begin
                m_sent++;
                e_tvld = m_word;
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("model_tvld", bus.TVLD_L, e_tvld);
            check("model_busy", 32'(bus.o_busy), 32'(e_busy));
            check("model_done", 32'(bus.o_pattern_done), 32'(e_done));
        end
    end

    task automatic step();
        @(negedge i_clk);
    endtask

    // Start a run in mode m; k counts cycles after the start cycle.
    task automatic run(input logic [1:0] m, input int stop_at,
                       input int kill_at, input bit kill_mode,
                       input int inj_at, input int len,
                       output int pat, output int done_at,
                       output logic [31:0] kill_tvld,
                       output logic kill_busy,
                       output logic [31:0] inj_word);
        {bus.i_enable_cons, bus.i_enable_128} = m;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        pat = 0;
        done_at = 0;
        kill_tvld = '1;
        kill_busy = 1'b1;
        inj_word = '0;
        for (int k = 1; k <= len; k++) begin
            if (bus.TVLD_L != 32'h0) pat++;
            if (bus.o_pattern_done) done_at = k;
            if (k == kill_at + 1) begin
                kill_tvld = bus.TVLD_L;
                kill_busy = bus.o_busy;
            end
            if (k == inj_at + 1) inj_word = bus.TVLD_L;
            bus.i_stop = (k == stop_at);
            if (k == kill_at) begin
                if (kill_mode) {bus.i_enable_cons, bus.i_enable_128} = 2'b00;
                else bus.i_enable_generator = 1'b0;
            end
`ifdef VALID_ERR_INJECT_EN
            bus.i_inject_err = (k == inj_at);
`endif
            step();
        end
        bus.i_stop = 1'b0;
        bus.i_enable_generator = 1'b1;
    endtask

    int          pat;
    int          dn;
    logic [31:0] kt;
    logic        kb;
    logic [31:0] iw;
    logic [31:0] dv_exp [4];
    logic        dv_seq [4];

    initial begin
        bus.i_enable_generator = 1'b1;
        bus.i_enable_128 = 1'b0;
        bus.i_enable_cons = 1'b0;
        bus.i_start = 1'b0;
        bus.i_stop = 1'b0;
        bus.i_data_valid = 1'b0;
`ifdef VALID_ERR_INJECT_EN
        bus.i_inject_err = 1'b0;
        bus.i_err_mask = 32'h0000_0003;
`endif
        step();
        step();
        check("rst_tvld", bus.TVLD_L, 32'h0);
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        check("rst_done", 32'(bus.o_pattern_done), 32'h0);
        i_rst_n = 1'b1;
        chk_en = 1'b1;
        step();
        step();
        check("idle_tvld", bus.TVLD_L, 32'h0);
        check("idle_busy", 32'(bus.o_busy), 32'h0);

        // Burst: 32 beats, done at T+33, idle after.
        run(2'b01, 0, 0, 0, 0, 34, pat, dn, kt, kb, iw);
        check("burst_beats", 32'(pat), 32'd32);
        check("burst_done_at", 32'(dn), 32'd33);
        check("burst_busy_end", 32'(bus.o_busy), 32'h0);

        // Continuous: stop at T+20.
        run(2'b10, 20, 0, 0, 0, 24, pat, dn, kt, kb, iw);
        check("cont_beats", 32'(pat), 32'd20);
        check("cont_done_at", 32'(dn), 32'd21);

        // Long continuous run past the counter range.
        run(2'b10, 300, 0, 0, 0, 303, pat, dn, kt, kb, iw);
        check("cont_long_beats", 32'(pat), 32'd300);
        check("cont_long_done", 32'(dn), 32'd301);

        // Disable at beat 10 aborts with no done pulse.
        run(2'b01, 0, 10, 0, 0, 16, pat, dn, kt, kb, iw);
        check("abort_beats", 32'(pat), 32'd10);
        check("abort_tvld", kt, 32'h0);
        check("abort_busy", 32'(kb), 32'h0);
        check("abort_no_done", 32'(dn), 32'd0);
        run(2'b01, 0, 0, 0, 0, 34, pat, dn, kt, kb, iw);
        check("reburst_beats", 32'(pat), 32'd32);
        check("reburst_done_at", 32'(dn), 32'd33);

        // Mode change out of CONT aborts.
        run(2'b10, 0, 5, 1, 0, 10, pat, dn, kt, kb, iw);
        check("mchg_beats", 32'(pat), 32'd5);
        check("mchg_no_done", 32'(dn), 32'd0);

        // i_stop in BURST has no effect.
        run(2'b01, 7, 0, 0, 0, 34, pat, dn, kt, kb, iw);
        check("bstop_beats", 32'(pat), 32'd32);
        check("bstop_done_at", 32'(dn), 32'd33);

        // Mission framing, one cycle latency.
        {bus.i_enable_cons, bus.i_enable_128} = 2'b00;
        dv_seq = '{1'b1, 1'b0, 1'b1, 1'b1};
        dv_exp = '{P, 32'h0, P, P};
        for (int i = 0; i < 4; i++) begin
            bus.i_data_valid = dv_seq[i];
            step();
            check("mission_tvld", bus.TVLD_L, dv_exp[i]);
        end
        bus.i_data_valid = 1'b0;
        step();
        check("mission_tail", bus.TVLD_L, 32'h0);

        // Illegal mode 11 ignores start.
        {bus.i_enable_cons, bus.i_enable_128} = 2'b11;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        check("ill_busy", 32'(bus.o_busy), 32'h0);
        check("ill_tvld", bus.TVLD_L, 32'h0);
        step();
        check("ill_busy2", 32'(bus.o_busy), 32'h0);

        // Start ignored with enable low.
        {bus.i_enable_cons, bus.i_enable_128} = 2'b01;
        bus.i_enable_generator = 1'b0;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        bus.i_enable_generator = 1'b1;
        check("dis_start_busy", 32'(bus.o_busy), 32'h0);
        step();

        // Asynchronous reset mid-burst.
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_busy", 32'(bus.o_busy), 32'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_tvld", bus.TVLD_L, 32'h0);
        check("arst_busy", 32'(bus.o_busy), 32'h0);
        step();
        i_rst_n = 1'b1;
        step();
        check("post_rst_busy", 32'(bus.o_busy), 32'h0);

`ifdef VALID_ERR_INJECT_EN
        // Error injection on beat 5 only.
        run(2'b01, 0, 0, 0, 4, 34, pat, dn, kt, kb, iw);
        check("inj_word", iw, 32'hF0F0_F0F3);
        check("inj_beats", 32'(pat), 32'd32);
        check("inj_done_at", 32'(dn), 32'd33);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
